acc_arbiter: RTL
================

# acc_arbiter

Round-robin write-port arbiter for the accumulator. It sits between four datapath requesters and the accumulator's single load port:
- **Requesters:** 0 = ALU result, 1 = memory load, 2 = I/O port, 3 = immediate/control.
- **Per cycle:** selects at most one writer and drives the accumulator's load enable and load data from registers.
- **Flag capture:** samples the accumulator's zero/negative flags one cycle after every write and returns them tagged with the writer's ID.
- **Bus lock:** supports a bounded lock so one requester can issue back-to-back read-modify-write sequences.

## Interface
Parameters:
- DataWidth, 32, accumulator data width.
- MaxLock, 8, maximum consecutive grants to a locking requester while others wait (range 1–15).

Ports:
- clock  in  1  system clock; arbiter logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Req  in  4  per-requester write request; level, held until Ack.
- Lock  in  4  per-requester lock; meaningful only with Req of the same bit.
- ReqData  in  4*DataWidth  flat bus; requester i uses bits [i*DataWidth +: DataWidth].
- ACCZero  in  1  accumulator zero flag.
- ACCNeg  in  1  accumulator negative flag.
- ACCInEn  out  1  accumulator load enable (registered).
- ACCDataIn  out  DataWidth  accumulator load data (registered).
- Ack  out  4  one-hot pulse; write issued for that requester this cycle.
- GrantId  out  2  ID of the current or most recent writer.
- FlagValid  out  1  one-cycle pulse; FlagZero/FlagNeg/FlagId are valid.
- FlagZero  out  1  captured ACCZero.
- FlagNeg  out  1  captured ACCNeg.
- FlagId  out  2  writer whose result the flags describe.
- Busy  out  1  high in WRITE or LOCKED.

## Operation
- **FSM states:** IDLE, WRITE, LOCKED.
- **IDLE:**
  - Any Req set: go to WRITE, or to LOCKED if the winner's Lock is set.
  - No Req set: stay in IDLE.
- **WRITE:**
  - Next winner is chosen by round-robin.
  - Winner's Lock set: go to LOCKED.
  - No Req set: go to IDLE.
- **LOCKED:**
  - Owner keeps Req and Lock high and LockCnt < MaxLock: owner wins again and LockCnt increments.
  - Owner drops Req or Lock: fall back to round-robin and go to WRITE or IDLE.
  - LockCnt == MaxLock and another Req is pending: owner is refused for that cycle, the round-robin winner is granted, and LockCnt clears.
  - LockCnt == MaxLock and no other Req is pending: owner continues and LockCnt saturates.
- **Round-robin:**
  - Pointer Last holds the most recent winner.
  - Search order is Last+1, Last+2, … modulo 4.
  - Last updates on every grant, including locked grants.
- **Grant actions:** on a grant edge the arbiter registers:
  - ACCInEn=1;
  - ACCDataIn = the winner's ReqData slice;
  - Ack[winner]=1 and GrantId=winner.
- **No grant:** ACCInEn=0 and Ack=0. ACCDataIn and GrantId hold their values.
- **Requester contract:** drop Req, or present new data, in the cycle after Ack. A Req still high after Ack is a new request.
- **Lock without Req:** ignored.
- **Req removed before grant:** no write is issued. No abort is needed.
- **Reset values:** FSM=IDLE, Last=3 (requester 0 first), LockCnt=0, and all outputs 0.

## Timing
- **Grant latency:** Req sampled at rising edge N → ACCInEn/Ack high from N to N+1.
- **Accumulator load:** the accumulator loads on the falling edge within that cycle.
- **Flag capture:** at rising edge N+1 the arbiter captures ACCZero/ACCNeg into FlagZero/FlagNeg, sets FlagId = GrantId of edge N, and pulses FlagValid for one cycle.
- **Back-to-back writes:**
  - Throughput is one write per cycle.
  - Flags for write k and ACCInEn for write k+1 are asserted in the same cycle.
  - Flags always describe the previous write only.
- **Reset mid-operation:**
  - Any pending FlagValid is suppressed, because the accumulator has also been cleared.
  - The lock is released.
  - The first post-reset grant goes to the lowest requesting ID.

## Structure
- **Shared package:** state encoding (IDLE=0, WRITE=1, LOCKED=2), NumReq=4, IdWidth=2, and the one-hot Ack helper constants.
- **Sub-module acc_rr_pick:** combinational. Inputs are Req[3:0], Last[1:0], and a mask of the refused owner. Outputs are Valid and Winner[1:0]. The main block holds the FSM, LockCnt, pointer, and output registers.

## Test plan
- **Single request:** reset, then Req=0100 with ReqData[2]=0x0000_0000 → Ack=0100 and ACCInEn=1 with ACCDataIn=0 one cycle after Req; next cycle FlagValid=1, FlagZero=1, FlagNeg=0, FlagId=2.
- **Round-robin:** Req=1111 held, each requester re-requests after Ack → grant order 0,1,2,3,0, with ACCInEn high every cycle.
- **Lock bound (MaxLock=8):** Req=0011, Lock=0001, requester 0 held → requester 0 granted 9 times (initial grant plus 8 locked), requester 1 granted on cycle 10, then requester 0 again.
- **Negative flag:** requester 1 writes 0x8000_0001 then 0x0000_0005 back-to-back → FlagNeg=1 then 0, FlagId=1 both times, one cycle behind each Ack.
- **Reset mid-lock:** assert reset during LOCKED with a write in flight → all outputs 0 immediately, no FlagValid after release, first grant to lowest requesting ID.
- **Request withdrawn:** Req=0010 raised and dropped before the sampling edge → no Ack, ACCInEn stays 0, FSM stays IDLE.

Source files
------------

// File: rtl/acc_arbiter_pkg.sv
// Shared definitions for the accumulator write-port arbiter: state encoding,
// requester count/ID width and the one-hot acknowledge constants.
package acc_arbiter_pkg;

  localparam int NumReq  = 4;
  localparam int IdWidth = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam logic [NumReq-1:0] AckNone = 4'b0000;
  localparam logic [NumReq-1:0] AckAlu  = 4'b0001;
  localparam logic [NumReq-1:0] AckMem  = 4'b0010;
  localparam logic [NumReq-1:0] AckIo   = 4'b0100;
  localparam logic [NumReq-1:0] AckImm  = 4'b1000;

  function automatic logic [NumReq-1:0] ack_onehot(input logic [IdWidth-1:0] id);
    logic [NumReq-1:0] oh;
    case (id)
      2'd0:    oh = AckAlu;
      2'd1:    oh = AckMem;
      2'd2:    oh = AckIo;
      default: oh = AckImm;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/acc_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo 4,
// skipping any requester set in the refusal mask.
module acc_rr_pick
  import acc_arbiter_pkg::*;
(
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] last,
  input  logic [NumReq-1:0]  mask,
  output logic               valid,
  output logic [IdWidth-1:0] winner
);

  logic [NumReq-1:0]  eligible;
  logic [IdWidth-1:0] idx;

  assign eligible = req & ~mask;

  // Walk from the lowest priority (last itself) up to last+1 so the final
  // hit is the closest requester after the pointer.
  always_comb begin
    valid  = 1'b0;
    winner = last;
    idx    = last;
    for (int i = NumReq; i >= 1; i--) begin
      idx = last + IdWidth'(i);
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin write-port arbiter for the accumulator load port with bounded
// bus lock and one-cycle-delayed flag capture tagged by writer ID.
//
//   state  | meaning
//   IDLE   | no write issued this cycle
//   WRITE  | round-robin write issued this cycle
//   LOCKED | write issued to a locking requester (owner = last)
module acc_arbiter
  import acc_arbiter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MaxLock   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NumReq-1:0]             Req,
  input  logic [NumReq-1:0]             Lock,
  input  logic [NumReq*DataWidth-1:0]   ReqData,
  input  logic                          ACCZero,
  input  logic                          ACCNeg,
  output logic                          ACCInEn,
  output logic [DataWidth-1:0]          ACCDataIn,
  output logic [NumReq-1:0]             Ack,
  output logic [IdWidth-1:0]            GrantId,
  output logic                          FlagValid,
  output logic                          FlagZero,
  output logic                          FlagNeg,
  output logic [IdWidth-1:0]            FlagId,
  output logic                          Busy
);

  localparam logic [3:0] MaxLockC = 4'(MaxLock);

  arb_state_e          state, next_state;
  logic [IdWidth-1:0]  last;
  logic [3:0]          lock_cnt, next_cnt;
  logic                grant;
  logic [IdWidth-1:0]  win_id;
  logic                owner_hold;
  logic                at_bound;
  logic [NumReq-1:0]   refuse_mask;
  logic                pick_valid;
  logic [IdWidth-1:0]  pick_winner;
  logic [DataWidth-1:0] req_word [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign req_word[g] = ReqData[g*DataWidth +: DataWidth];
  end

  // In LOCKED the owner is always the most recent winner.
  assign owner_hold  = (state == LOCKED) && Req[last] && Lock[last];
  assign at_bound    = (lock_cnt >= MaxLockC);
  assign refuse_mask = (owner_hold && at_bound) ? ack_onehot(last) : AckNone;

  acc_rr_pick u_pick (
    .req    (Req),
    .last   (last),
    .mask   (refuse_mask),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    next_state = IDLE;
    next_cnt   = lock_cnt;
    grant      = 1'b0;
    win_id     = last;
    if (owner_hold && !at_bound) begin
      grant      = 1'b1;
      win_id     = last;
      next_cnt   = lock_cnt + 4'd1;
      next_state = LOCKED;
    end else if (owner_hold && !pick_valid) begin
      // Nobody else waiting: owner keeps the port, count stays saturated.
      grant      = 1'b1;
      win_id     = last;
      next_state = LOCKED;
    end else if (pick_valid) begin
      grant      = 1'b1;
      win_id     = pick_winner;
      next_cnt   = 4'd0;
      next_state = Lock[pick_winner] ? LOCKED : WRITE;
    end else begin
      next_cnt   = 4'd0;
      next_state = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 2'd3;
      lock_cnt  <= 4'd0;
      ACCInEn   <= 1'b0;
      ACCDataIn <= '0;
      Ack       <= AckNone;
      GrantId   <= '0;
      FlagValid <= 1'b0;
      FlagZero  <= 1'b0;
      FlagNeg   <= 1'b0;
      FlagId    <= '0;
    end else begin
      state    <= next_state;
      lock_cnt <= next_cnt;
      ACCInEn  <= grant;
      if (grant) begin
        ACCDataIn <= req_word[win_id];
        Ack       <= ack_onehot(win_id);
        GrantId   <= win_id;
        last      <= win_id;
      end else begin
        Ack <= AckNone;
      end
      // The accumulator loaded on the falling edge of the grant cycle.
      FlagValid <= ACCInEn;
      if (ACCInEn) begin
        FlagZero <= ACCZero;
        FlagNeg  <= ACCNeg;
        FlagId   <= GrantId;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule
